// File: rtl/logip_pkg.sv
// Shared types and widths for the capture controller and its helpers.
package logip_pkg;

    localparam int CFG_CNT_W = 16;
    localparam int DIV_W     = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample RAM port and readout stream of the capture controller.
interface capture_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int SMPL_W = 32
);
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [SMPL_W-1:0] mem_wdata_o;
    logic [SMPL_W-1:0] mem_rdata_i;
    logic [SMPL_W-1:0] tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i;

    modport master (
        output mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output tx_data_o, tx_valid_o,
        input  tx_ready_i
    );

    modport slave (
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  tx_data_o, tx_valid_o,
        output tx_ready_i
    );
endinterface

// File: rtl/capture_ctrl_load_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
module load_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: pre/post-trigger sampling into a ring RAM, then streamed readout.
//   state      | meaning
//   ST_IDLE    | waiting for arm; cfg_stb accepted here only
//   ST_ARMED   | writing pre-trigger samples, waiting for trig
//   ST_DELAY   | writing post-trigger samples until delay counter is zero
//   ST_RD_ADDR | presenting read address to the RAM
//   ST_RD_DATA | capturing RAM data and holding it until the sink accepts
module capture_ctrl
    import logip_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SMPL_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_W-1:0]     cfg_div_i,
    input  logic [CFG_CNT_W-1:0] cfg_cnt_i,
    input  logic [CFG_CNT_W-1:0] cfg_dly_i,
    input  logic                 cfg_stb_i,
    input  logic                 arm_i,
    input  logic                 trig_i,
    input  logic                 abort_i,
    output logic [DIV_W-1:0]     fdiv_o,
    output logic                 set_div_o,
    input  logic [SMPL_W-1:0]    smpl_i,
    input  logic                 smpl_stb_i,
    capture_ctrl_if.master       bus,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int RCAP_W = CFG_CNT_W + 1;
    localparam logic [RCAP_W-1:0] DEPTH_CAP =
        (ADDR_W >= RCAP_W) ? {RCAP_W{1'b1}} : (RCAP_W'(1) << ADDR_W);

    state_t state_q, state_d;

    logic [CFG_CNT_W-1:0] cfg_cnt_q, cfg_dly_q, n_rd;
    logic [DIV_W-1:0]     fdiv_q;
    logic                 set_div_q;
    logic [ADDR_W-1:0]    wptr_q, rptr_q, wr_addr_q;
    logic [SMPL_W-1:0]    wdata_q, tx_data_q;
    logic                 we_q, tx_valid_q, done_q;

    logic cfg_load, wr_en, dly_load, dly_dec, dly_zero;
    logic rd_load, rd_dec, rd_zero, rd_fetch, xfer, done_set;

    // Words to read back can never exceed what the ring holds.
    assign n_rd = ({1'b0, cfg_cnt_q} > DEPTH_CAP) ? CFG_CNT_W'(DEPTH_CAP) : cfg_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_load = 1'b0;
        wr_en    = 1'b0;
        dly_load = 1'b0;
        dly_dec  = 1'b0;
        rd_load  = 1'b0;
        rd_dec   = 1'b0;
        rd_fetch = 1'b0;
        xfer     = 1'b0;
        done_set = 1'b0;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cfg_load = cfg_stb_i;
                    if (arm_i) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    wr_en = smpl_stb_i;
                    if (trig_i) begin
                        state_d  = ST_DELAY;
                        dly_load = 1'b1;
                    end
                end
                ST_DELAY: begin
                    // Once the post-trigger budget is spent no further sample is stored.
                    if (dly_zero) begin
                        if (n_rd == '0) begin
                            state_d  = ST_IDLE;
                            done_set = 1'b1;
                        end else begin
                            state_d = ST_RD_ADDR;
                            rd_load = 1'b1;
                        end
                    end else begin
                        wr_en   = smpl_stb_i;
                        dly_dec = smpl_stb_i;
                    end
                end
                ST_RD_ADDR: state_d = ST_RD_DATA;
                ST_RD_DATA: begin
                    if (!tx_valid_q) begin
                        rd_fetch = 1'b1;
                    end else if (bus.tx_ready_i) begin
                        xfer   = 1'b1;
                        rd_dec = 1'b1;
                        if (rd_zero) begin
                            state_d  = ST_IDLE;
                            done_set = 1'b1;
                        end else begin
                            state_d = ST_RD_ADDR;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_cnt_q  <= '0;
            cfg_dly_q  <= '0;
            fdiv_q     <= '0;
            set_div_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            wr_addr_q  <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            set_div_q <= cfg_load;
            if (cfg_load) begin
                cfg_cnt_q <= cfg_cnt_i;
                cfg_dly_q <= cfg_dly_i;
                fdiv_q    <= cfg_div_i;
            end
            we_q <= wr_en;
            if (wr_en) begin
                wr_addr_q <= wptr_q;
                wdata_q   <= smpl_i;
                wptr_q    <= wptr_q + ADDR_W'(1);
            end
            if (rd_load) begin
                rptr_q <= wptr_q - ADDR_W'(n_rd);
            end else if (xfer) begin
                rptr_q <= rptr_q + ADDR_W'(1);
            end
            if (abort_i) begin
                tx_valid_q <= 1'b0;
            end else if (rd_fetch) begin
                tx_data_q  <= bus.mem_rdata_i;
                tx_valid_q <= 1'b1;
            end else if (xfer) begin
                tx_valid_q <= 1'b0;
            end
            done_q <= done_set;
        end
    end

    load_cnt #(.W(CFG_CNT_W)) u_dly_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (dly_load),
        .load_val_i (cfg_dly_q),
        .dec_i      (dly_dec),
        .zero_o     (dly_zero)
    );

    // Loaded with words-after-this-one, so zero marks the final transfer.
    load_cnt #(.W(CFG_CNT_W)) u_rd_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (rd_load),
        .load_val_i (n_rd - CFG_CNT_W'(1)),
        .dec_i      (rd_dec),
        .zero_o     (rd_zero)
    );

    assign fdiv_o          = fdiv_q;
    assign set_div_o       = set_div_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = (state_q == ST_RD_ADDR || state_q == ST_RD_DATA) ? rptr_q : wr_addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_valid_o  = tx_valid_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = done_q;
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, giving the sample RAM address width (depth 2**ADDR_W).
REQ-002 The module SHALL have parameter SMPL_W, default 32, giving the sample width.
REQ-003 Port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 Port cfg_div_i, input, 24: sampler divider value.
REQ-006 Port cfg_cnt_i, input, 16: number of samples to read out.
REQ-007 Port cfg_dly_i, input, 16: number of post-trigger samples.
REQ-008 Port cfg_stb_i, input, 1: latch all cfg_* inputs.
REQ-009 Port arm_i, input, 1: start capture.
REQ-010 Port trig_i, input, 1: trigger event.
REQ-011 Port abort_i, input, 1: return to idle.
REQ-012 Port fdiv_o, output, 24: divider value to the sampler.
REQ-013 Port set_div_o, output, 1: one-cycle load strobe to the sampler.
REQ-014 Port smpl_i, input, SMPL_W: sampler data.
REQ-015 Port smpl_stb_i, input, 1: sample valid.
REQ-016 Port mem_we_o, output, 1: RAM write enable.
REQ-017 Port mem_addr_o, output, ADDR_W: RAM address.
REQ-018 Port mem_wdata_o, output, SMPL_W: RAM write data.
REQ-019 Port mem_rdata_i, input, SMPL_W: RAM read data, valid 1 cycle after address.
REQ-020 Port tx_data_o, output, SMPL_W; port tx_valid_o, output, 1; port tx_ready_i, input, 1: readout stream.
REQ-021 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-022 Port done_o, output, 1: one-cycle pulse on readout completion.

Function
REQ-023 The controller SHALL implement states IDLE, ARMED, DELAY, RD_ADDR and RD_DATA.
REQ-024 In IDLE, cfg_stb_i SHALL latch the cfg values and, on the next cycle, drive fdiv_o with the latched divider and pulse set_div_o for 1 cycle.
REQ-025 cfg_stb_i outside IDLE SHALL be ignored.
REQ-026 IDLE SHALL go to ARMED on arm_i.
REQ-027 In ARMED and DELAY, each smpl_stb_i SHALL produce, 1 cycle later, mem_we_o=1 with mem_addr_o=wptr and mem_wdata_o=smpl_i; wptr then increments modulo 2**ADDR_W.
REQ-028 ARMED SHALL go to DELAY on trig_i, loading the remaining-delay counter with cfg_dly.
REQ-029 A sample arriving together with trig_i SHALL be written and counted as pre-trigger.
REQ-030 In DELAY, each write SHALL decrement the delay counter; when the counter reaches 0, the state SHALL go to RD_ADDR. cfg_dly=0 goes to RD_ADDR on the cycle after the trigger.
REQ-031 On entering readout: rptr = wptr - N (mod depth), where N = min(cfg_cnt, 2**ADDR_W), oldest sample first.
REQ-032 If cfg_cnt=0, the state SHALL go to IDLE with done_o and emit no data.
REQ-033 RD_ADDR SHALL drive mem_addr_o=rptr with mem_we_o=0, then go to RD_DATA.
REQ-034 RD_DATA SHALL register mem_rdata_i into tx_data_o and assert tx_valid_o.
REQ-035 tx_data_o and tx_valid_o SHALL be held stable until tx_ready_i=1.
REQ-036 After a transfer, rptr SHALL increment with wrap and the remaining count SHALL decrement; if the count reaches 0, the state SHALL go to IDLE, pulse done_o and drop tx_valid_o; otherwise it SHALL go to RD_ADDR.
REQ-037 smpl_stb_i and trig_i SHALL be ignored outside ARMED and DELAY, respectively outside ARMED.
REQ-038 abort_i in any state SHALL return to IDLE on the next edge, drop tx_valid_o and mem_we_o, and not pulse done_o.
REQ-039 abort_i SHALL take priority over simultaneous arm_i, trig_i and handshake.
REQ-040 wptr SHALL persist across captures and reset only on rst_i.

Reset
REQ-041 rst_i SHALL force: state IDLE; wptr, rptr and all counters 0; latched cfg 0; fdiv_o=0; set_div_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; tx_data_o=0; tx_valid_o=0; busy_o=0; done_o=0.
REQ-042 Reset mid-capture or mid-readout SHALL discard the transfer with no done_o.

Structure
REQ-043 The state enum typedef, CFG_CNT_W=16 and DIV_W=24 SHALL reside in shared package logip_pkg.
REQ-044 One sub-module, load_cnt (loadable down-counter with zero flag), SHALL be used for both the delay and readout counters.

Verification
REQ-045 The bench SHALL cover: cfg_div=0x000010 with cfg_stb in IDLE -> fdiv_o=0x000010 and a single set_div_o pulse 1 cycle later; cfg_stb while ARMED -> no pulse.
REQ-046 The bench SHALL cover: ADDR_W=4, arm, 20 samples 0..19, trig after sample 9, cfg_dly=4, cfg_cnt=8 -> writes stop after sample 13; readout 6..13 in order, then done_o.
REQ-047 The bench SHALL cover: cfg_dly=0, cfg_cnt=3, trig together with the sample 0xA5 -> that sample is stored; readout ends with 0xA5.
REQ-048 The bench SHALL cover: cfg_cnt=40 with ADDR_W=4 -> exactly 16 words, oldest first, with address wrap correct.
REQ-049 The bench SHALL cover: tx_ready_i held low 5 cycles -> tx_data_o stable; then abort_i -> IDLE, tx_valid_o=0, no done_o.
REQ-050 The bench SHALL cover: rst_i asserted in DELAY -> all outputs 0 immediately; a new capture then starts with wptr=0.
